// File: rtl/dac_spi_multi.sv
// Multi-channel serial DAC driver: shifts one word per enabled channel MSB first
// and strobes LDAC_N after each frame or once after the last frame.
module dac_spi_multi #(
  parameter int DATA_W  = 16,
  parameter int N_CH    = 4,
  parameter int CLK_DIV = 4,
  parameter int T_CSH   = 2,
  parameter int T_LS    = 4,
  parameter int T_LD    = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       start,
  input  logic                       sync_mode,
  input  logic [N_CH-1:0]            ch_mask,
  input  logic [N_CH*DATA_W-1:0]     data,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_CH)-1:0]    ch_idx,
  output logic                       sck,
  output logic                       cs_n,
  output logic                       sdi,
  output logic                       ldac_n
);

  localparam int IW   = $clog2(N_CH);
  localparam int BW   = $clog2(DATA_W);
  localparam int M1   = (CLK_DIV > T_CSH) ? CLK_DIV : T_CSH;
  localparam int M2   = (T_LS > T_LD) ? T_LS : T_LD;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_DIV = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_CSH = CW'(T_CSH - 1);
  localparam logic [CW-1:0] C_LS  = CW'(T_LS - 1);
  localparam logic [CW-1:0] C_LD  = CW'(T_LD - 1);
  localparam logic [CW-1:0] C_MAX = CW'(CMAX);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CSH   = 3'd3;
  localparam logic [2:0] S_LS    = 3'd4;
  localparam logic [2:0] S_LD    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]             r_state;
  logic [N_CH*DATA_W-1:0] r_data;
  logic [N_CH-1:0]        r_pend;
  logic                   r_sync;
  logic [DATA_W-1:0]      r_shift;
  logic [BW-1:0]          r_bits;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          r_since;

  logic                   w_found;
  logic [IW-1:0]          w_idx;
  logic [DATA_W-1:0]      w_word;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (r_pend[i] && !w_found) begin
        w_found = 1'b1;
        w_idx   = IW'(i);
      end
    end
  end

  assign w_word = r_data[w_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_pend  <= '0;
      r_sync  <= 1'b0;
      r_shift <= '0;
      r_bits  <= '0;
      r_cnt   <= '0;
      r_since <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ch_idx  <= '0;
      sck     <= 1'b0;
      cs_n    <= 1'b1;
      sdi     <= 1'b0;
      ldac_n  <= 1'b1;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_since <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ch_idx  <= '0;
      sck     <= 1'b0;
      cs_n    <= 1'b1;
      sdi     <= 1'b0;
      ldac_n  <= 1'b1;
    end else begin
      // r_since runs from CS_N rising through CSH/SEL/LS so CSH time counts toward T_LS
      if (r_since != C_MAX) r_since <= r_since + CW'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_data <= data;
            r_pend <= ch_mask;
            r_sync <= sync_mode;
            busy   <= 1'b1;
            if (ch_mask == '0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SEL;
            end
          end
        end
        S_SEL: begin
          if (w_found) begin
            ch_idx        <= w_idx;
            r_pend[w_idx] <= 1'b0;
            r_shift       <= w_word;
            sdi           <= w_word[DATA_W-1];
            cs_n          <= 1'b0;
            sck           <= 1'b0;
            r_cnt         <= '0;
            r_bits        <= '0;
            r_state       <= S_SHIFT;
          end else if (r_sync) begin
            r_state <= S_LS;
          end else begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_SHIFT: begin
          if (r_cnt == C_DIV) begin
            r_cnt <= '0;
            sck   <= ~sck;
            if (sck) begin
              if (r_bits == B_LAST) begin
                cs_n    <= 1'b1;
                sdi     <= 1'b0;
                r_since <= '0;
                r_state <= S_CSH;
              end else begin
                r_bits  <= r_bits + BW'(1);
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                sdi     <= r_shift[DATA_W-2];
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CSH: begin
          if (r_since >= C_CSH) r_state <= r_sync ? S_SEL : S_LS;
        end
        S_LS: begin
          if (r_since >= C_LS) begin
            ldac_n  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_LD;
          end
        end
        S_LD: begin
          if (r_cnt == C_LD) begin
            ldac_n <= 1'b1;
            if (r_sync) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SEL;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          ch_idx  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench for dac_spi_multi: a pin monitor rebuilds frames and strobe timing.
module tb_dac_spi_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        sync_mode = 1'b0;
  logic [3:0]  ch_mask = '0;
  logic [63:0] data = '0;
  logic        busy, done, sck, cs_n, sdi, ldac_n;
  logic [1:0]  ch_idx;

  int total = 0;
  int bad   = 0;

  dac_spi_multi #(.DATA_W(16), .N_CH(4), .CLK_DIV(4), .T_CSH(2), .T_LS(4), .T_LD(7)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .sync_mode(sync_mode),
    .ch_mask(ch_mask), .data(data), .busy(busy), .done(done), .ch_idx(ch_idx),
    .sck(sck), .cs_n(cs_n), .sdi(sdi), .ldac_n(ldac_n)
  );

  always #5 clk = ~clk;

  // pin monitor
  int          cyc = 0, nrise = 0, nbits = 0, cslen = 0, ldlen = 0, ndone = 0, viol = 0, cs_rise_cyc = 0;
  logic [15:0] bitbuf = '0;
  logic        p_cs = 1'b1, p_sck = 1'b0, p_ld = 1'b1;
  logic [15:0] fr_q[$];
  int          nb_q[$], len_q[$], idx_q[$], dly_q[$], wid_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!cs_n && p_cs) begin nbits = 0; bitbuf = '0; cslen = 0; end
    if (!cs_n) cslen++;
    if (sck && !p_sck) begin
      nrise++;
      if (!cs_n) begin bitbuf = {bitbuf[14:0], sdi}; nbits++; end
    end
    if ((sck != p_sck) && cs_n && p_cs) viol++;
    if (!ldac_n && !cs_n) viol++;
    if (cs_n && !p_cs) begin
      fr_q.push_back(bitbuf); nb_q.push_back(nbits); len_q.push_back(cslen);
      idx_q.push_back(int'(ch_idx)); cs_rise_cyc = cyc;
    end
    if (!ldac_n && p_ld) dly_q.push_back(cyc - cs_rise_cyc);
    if (!ldac_n) ldlen++;
    if (ldac_n && !p_ld) begin wid_q.push_back(ldlen); ldlen = 0; end
    if (done) ndone++;
    p_cs = cs_n; p_sck = sck; p_ld = ldac_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    fr_q.delete(); nb_q.delete(); len_q.delete(); idx_q.delete(); dly_q.delete(); wid_q.delete();
    nrise = 0; ndone = 0; viol = 0; ldlen = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_frames(input string tag, input logic [15:0] w[3], input int ix[3], input int n);
    check({tag, "_nframes"}, fr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_word"}, {16'd0, fr_q[i]}, {16'd0, w[i]});
      check({tag, "_nbits"}, nb_q[i], 16);
      check({tag, "_cslen"}, len_q[i], 128);
      check({tag, "_idx"}, idx_q[i], ix[i]);
    end
  endtask

  task automatic check_ldac(input string tag, input int n);
    check({tag, "_npulse"}, wid_q.size(), n);
    check({tag, "_ndly"}, dly_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_width"}, wid_q[i], 7);
      check({tag, "_delay"}, dly_q[i], 4);
    end
  endtask

  logic [15:0] w3[3];
  int          ix3[3];
  logic [15:0] w1[3];
  int          ix1[3];
  int          n;

  initial begin
    // 1: reset with activity on start/enable
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 start = ~start; enable = ~enable;
      @(negedge clk);
      check("reset_idle", {24'd0, busy, done, ch_idx, sck, cs_n, sdi, ldac_n}, 32'b0000_0101);
    end
    check("reset_rises", nrise, 0);
    start = 1'b0; enable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clr();

    // 2: single channel, per-channel LDAC
    ch_mask = 4'b0001; sync_mode = 1'b0; data = {48'd0, 16'hA5C3};
    pulse_start();
    check("s2_busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle("s2", 1000);
    w1 = '{16'hA5C3, 16'h0, 16'h0}; ix1 = '{0, 0, 0};
    check_frames("s2", w1, ix1, 1);
    check("s2_rises", nrise, 16);
    check_ldac("s2", 1);
    check("s2_done", ndone, 1);
    check("s2_viol", viol, 0);
    clr();

    // 3: sync mode, mask 1011, second start and data change while busy
    ch_mask = 4'b1011; sync_mode = 1'b1; data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    pulse_start();
    repeat (50) @(negedge clk);
    data = {4{16'hDEAD}}; ch_mask = 4'b1111;
    pulse_start();
    wait_idle("s3", 2000);
    w3 = '{16'h1111, 16'h2222, 16'h4444}; ix3 = '{0, 1, 3};
    check_frames("s3", w3, ix3, 3);
    check_ldac("s3", 1);
    check("s3_done", ndone, 1);
    check("s3_viol", viol, 0);
    repeat (30) @(negedge clk);
    check("s3_stays_idle", {31'd0, busy}, 32'd0);
    check("s3_ch_idx_idle", {30'd0, ch_idx}, 32'd0);
    clr();

    // 4: same channels, per-channel LDAC
    ch_mask = 4'b1011; sync_mode = 1'b0; data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    pulse_start();
    wait_idle("s4", 2000);
    check_frames("s4", w3, ix3, 3);
    check_ldac("s4", 3);
    check("s4_done", ndone, 1);
    check("s4_viol", viol, 0);
    clr();

    // 5: empty mask
    ch_mask = 4'b0000; sync_mode = 1'b1;
    pulse_start();
    check("s5_done_first", {30'd0, busy, done}, 32'b11);
    @(posedge clk); #1;
    check("s5_done_second", {30'd0, busy, done}, 32'b00);
    repeat (20) @(negedge clk);
    check("s5_rises", nrise, 0);
    check("s5_frames", fr_q.size(), 0);
    check("s5_ldac", wid_q.size(), 0);
    check("s5_done", ndone, 1);
    clr();

    // 6: abort at 5th sck rise, then a clean rerun
    ch_mask = 4'b0001; sync_mode = 1'b0; data = {48'd0, 16'hA5C3};
    pulse_start();
    n = 0;
    while (nrise < 5 && n < 500) begin @(negedge clk); n++; end
    check("s6_reach5", nrise, 5);
    enable = 1'b0;
    @(negedge clk);
    check("s6_abort_pins", {28'd0, cs_n, sck, sdi, busy}, 32'b1000);
    repeat (200) @(negedge clk);
    check("s6_no_ldac", wid_q.size() + dly_q.size(), 0);
    check("s6_no_done", ndone, 0);
    check("s6_viol", viol, 0);
    clr();
    enable = 1'b1; data = {48'd0, 16'h5A3C};
    pulse_start();
    wait_idle("s6r", 1000);
    w1 = '{16'h5A3C, 16'h0, 16'h0};
    check_frames("s6r", w1, ix1, 1);
    check_ldac("s6r", 1);
    check("s6r_done", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
